axil_gpio_bank: RTL and testbench

Parametrised AXI4-Lite GPIO bank that drives NUM_PORTS tri-stateable Pmod-style ports of PORT_W bits each, with per-bit direction, output, synchronised input and rising-edge capture. Sits behind the MicroBlaze AXI-Lite control interconnect, alongside the display and peripheral logic in the board top. Replaces hard-wired per-header pin handling with one register-mapped block sized at build time.

---
 rtl/gpio_pkg.sv | 32 +++
 rtl/gpio_sync_edge.sv | 44 ++++
 rtl/axil_gpio_bank.sv | 264 ++++++++++++++++++++++++++
 tb/tb_axil_gpio_bank.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_pkg.sv
// Shared constants and FSM state types for the AXI-Lite GPIO bank.
package gpio_pkg;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 32;

  // Per-port register offsets (low nibble of the address)
  localparam logic [3:0] OFF_OUT  = 4'h0;
  localparam logic [3:0] OFF_TRI  = 4'h4;
  localparam logic [3:0] OFF_IN   = 4'h8;
  localparam logic [3:0] OFF_EDGE = 4'hC;

  // Global register addresses
  localparam logic [7:0] OFF_INFO     = 8'hF0;
  localparam logic [7:0] OFF_IRQ_MASK = 8'hF4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_ACK  = 2'd1,
    W_RESP = 2'd2
  } wr_state_t;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_ACK  = 2'd1,
    R_DATA = 2'd2
  } rd_state_t;

endpackage

// File: rtl/gpio_sync_edge.sv
// Two-flop input synchroniser for one GPIO port, with an optional rising-edge
// pulse on the synchronised value (present when GPIO_IRQ_EN is defined).
module gpio_sync_edge #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
`ifdef GPIO_IRQ_EN
  ,
  output logic [W-1:0] o_rise_c
`endif
);

  logic [W-1:0] r_meta;
  logic [W-1:0] r_sync;

  // Metastability filter: pad -> meta -> sync
  always_ff @(posedge clk) begin
    if (reset) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

`ifdef GPIO_IRQ_EN
  logic [W-1:0] r_prev;

  // Previous synchronised value for 0->1 detection
  always_ff @(posedge clk) begin
    if (reset) r_prev <= '0;
    else       r_prev <= r_sync;
  end

  assign o_rise_c = r_sync & ~r_prev;
`endif

endmodule

// File: rtl/axil_gpio_bank.sv
// AXI4-Lite GPIO bank: NUM_PORTS ports of PORT_W bits with OUT/TRI/IN/EDGE
// registers per port plus global INFO and IRQ_MASK.
// Optional feature macro: GPIO_IRQ_EN (edge capture, IRQ mask and irq output).
module axil_gpio_bank
  import gpio_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned PORT_W    = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [7:0]                    control_awaddr,
  input  logic                          control_awvalid,
  output logic                          control_awready,
  input  logic [31:0]                   control_wdata,
  input  logic                          control_wvalid,
  output logic                          control_wready,
  output logic [1:0]                    control_bresp,
  output logic                          control_bvalid,
  input  logic                          control_bready,
  input  logic [7:0]                    control_araddr,
  input  logic                          control_arvalid,
  output logic                          control_arready,
  output logic [31:0]                   control_rdata,
  output logic [1:0]                    control_rresp,
  output logic                          control_rvalid,
  input  logic                          control_rready,
  input  logic [NUM_PORTS*PORT_W-1:0]   gpio_i,
  output logic [NUM_PORTS*PORT_W-1:0]   gpio_o,
  output logic [NUM_PORTS*PORT_W-1:0]   gpio_t,
  output logic                          irq
);

  wr_state_t r_wstate, w_wstate_nxt;
  rd_state_t r_rstate, w_rstate_nxt;

  logic r_awready, r_bvalid, r_arready, r_rvalid;
  logic w_awready_nxt, w_bvalid_nxt, w_arready_nxt, w_rvalid_nxt;
  logic [1:0]  r_bresp, r_rresp;
  logic [31:0] r_rdata;

  logic [NUM_PORTS-1:0][PORT_W-1:0] r_out;
  logic [NUM_PORTS-1:0][PORT_W-1:0] r_tri;
  logic [NUM_PORTS-1:0][PORT_W-1:0] w_in;
  logic [NUM_PORTS-1:0][PORT_W-1:0] w_edge_rd;
  logic [NUM_PORTS-1:0]             w_mask_rd;

  logic [3:0]           w_wport, w_woff, w_rport, w_roff;
  logic [NUM_PORTS-1:0] w_wport_hit;
  logic                 w_wmapped, w_wr_en;
  logic                 w_rmapped;
  logic [31:0]          w_rdata_c;
  logic                 w_unused_wdata;

  assign w_wport = control_awaddr[7:4];
  assign w_woff  = control_awaddr[3:0];
  assign w_rport = control_araddr[7:4];
  assign w_roff  = control_araddr[3:0];
  // Register file is written on the edge that completes the AW/W handshake
  assign w_wr_en = (r_wstate == W_ACK);
  assign w_unused_wdata = ^control_wdata;

  // Write FSM: state and registered handshake outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wstate  <= W_IDLE;
      r_awready <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
    end else begin
      r_wstate  <= w_wstate_nxt;
      r_awready <= w_awready_nxt;
      r_bvalid  <= w_bvalid_nxt;
      if (w_wr_en) r_bresp <= w_wmapped ? RESP_OKAY : RESP_SLVERR;
    end
  end

  // Write FSM: next state; address and data must arrive together
  always_comb begin
    w_wstate_nxt = r_wstate;
    case (r_wstate)
      W_IDLE:  if (control_awvalid && control_wvalid) w_wstate_nxt = W_ACK;
      W_ACK:   w_wstate_nxt = W_RESP;
      W_RESP:  if (control_bready) w_wstate_nxt = W_IDLE;
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  // Write FSM: output decode of the upcoming state
  always_comb begin
    w_awready_nxt = 1'b0;
    w_bvalid_nxt  = 1'b0;
    if (w_wstate_nxt == W_ACK)  w_awready_nxt = 1'b1;
    if (w_wstate_nxt == W_RESP) w_bvalid_nxt  = 1'b1;
  end

  // Read FSM: state, registered handshake outputs and latched read data
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rresp   <= RESP_OKAY;
      r_rdata   <= '0;
    end else begin
      r_rstate  <= w_rstate_nxt;
      r_arready <= w_arready_nxt;
      r_rvalid  <= w_rvalid_nxt;
      if (r_rstate == R_ACK) begin
        r_rdata <= w_rdata_c;
        r_rresp <= w_rmapped ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  // Read FSM: next state
  always_comb begin
    w_rstate_nxt = r_rstate;
    case (r_rstate)
      R_IDLE:  if (control_arvalid) w_rstate_nxt = R_ACK;
      R_ACK:   w_rstate_nxt = R_DATA;
      R_DATA:  if (control_rready) w_rstate_nxt = R_IDLE;
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  // Read FSM: output decode of the upcoming state
  always_comb begin
    w_arready_nxt = 1'b0;
    w_rvalid_nxt  = 1'b0;
    if (w_rstate_nxt == R_ACK)  w_arready_nxt = 1'b1;
    if (w_rstate_nxt == R_DATA) w_rvalid_nxt  = 1'b1;
  end

  // Write address decode
  always_comb begin
    w_wport_hit = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (w_wport == 4'(p)) w_wport_hit[p] = 1'b1;
    end
    w_wmapped = ((|w_wport_hit) && (w_woff[1:0] == 2'b00)) ||
                (control_awaddr == OFF_INFO) || (control_awaddr == OFF_IRQ_MASK);
  end

  // Read address decode and data mux; unmapped reads return zero
  always_comb begin
    w_rdata_c = '0;
    w_rmapped = 1'b0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if ((w_rport == 4'(p)) && (w_roff[1:0] == 2'b00)) begin
        w_rmapped = 1'b1;
        case (w_roff)
          OFF_OUT:  w_rdata_c = 32'(r_out[p]);
          OFF_TRI:  w_rdata_c = 32'(r_tri[p]);
          OFF_IN:   w_rdata_c = 32'(w_in[p]);
          OFF_EDGE: w_rdata_c = 32'(w_edge_rd[p]);
          default:  w_rdata_c = '0;
        endcase
      end
    end
    if (control_araddr == OFF_INFO) begin
      w_rmapped = 1'b1;
      w_rdata_c = {16'h0000, 8'(PORT_W), 8'(NUM_PORTS)};
    end
    if (control_araddr == OFF_IRQ_MASK) begin
      w_rmapped = 1'b1;
      w_rdata_c = 32'(w_mask_rd);
    end
  end

  // OUT and TRI registers; bits above PORT_W are dropped
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out <= '0;
      r_tri <= '1;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (w_wr_en && w_wport_hit[p]) begin
          if (w_woff == OFF_OUT) r_out[p] <= control_wdata[PORT_W-1:0];
          if (w_woff == OFF_TRI) r_tri[p] <= control_wdata[PORT_W-1:0];
        end
      end
    end
  end

`ifdef GPIO_IRQ_EN
  logic [NUM_PORTS-1:0][PORT_W-1:0] w_rise;
  logic [NUM_PORTS-1:0][PORT_W-1:0] r_edge;
  logic [NUM_PORTS-1:0][PORT_W-1:0] w_clr;
  logic [NUM_PORTS-1:0]             r_irq_mask;
  logic [NUM_PORTS-1:0]             w_edge_any;
  logic                             r_irq;

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
    gpio_sync_edge #(.W(PORT_W)) u_sync (
      .clk      (clk),
      .reset    (reset),
      .i_d      (gpio_i[g*PORT_W +: PORT_W]),
      .o_q      (w_in[g]),
      .o_rise_c (w_rise[g])
    );
  end

  // Write-one-to-clear mask for EDGE
  always_comb begin
    w_clr = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (w_wr_en && w_wport_hit[p] && (w_woff == OFF_EDGE))
        w_clr[p] = control_wdata[PORT_W-1:0];
      w_edge_any[p] = |r_edge[p];
    end
  end

  // EDGE capture: a new rising edge beats a simultaneous clear
  always_ff @(posedge clk) begin
    if (reset) r_edge <= '0;
    else begin
      for (int p = 0; p < NUM_PORTS; p++)
        r_edge[p] <= (r_edge[p] & ~w_clr[p]) | w_rise[p];
    end
  end

  // IRQ mask register and registered level interrupt
  always_ff @(posedge clk) begin
    if (reset) begin
      r_irq_mask <= '0;
      r_irq      <= 1'b0;
    end else begin
      if (w_wr_en && (control_awaddr == OFF_IRQ_MASK))
        r_irq_mask <= control_wdata[NUM_PORTS-1:0];
      r_irq <= |(r_irq_mask & w_edge_any);
    end
  end

  assign w_edge_rd = r_edge;
  assign w_mask_rd = r_irq_mask;
  assign irq       = r_irq;
`else
  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
    gpio_sync_edge #(.W(PORT_W)) u_sync (
      .clk   (clk),
      .reset (reset),
      .i_d   (gpio_i[g*PORT_W +: PORT_W]),
      .o_q   (w_in[g])
    );
  end

  assign w_edge_rd = '0;
  assign w_mask_rd = '0;
  assign irq       = 1'b0;
`endif

  assign control_awready = r_awready;
  assign control_wready  = r_awready;
  assign control_bvalid  = r_bvalid;
  assign control_bresp   = r_bresp;
  assign control_arready = r_arready;
  assign control_rvalid  = r_rvalid;
  assign control_rresp   = r_rresp;
  assign control_rdata   = r_rdata;
  assign gpio_o          = r_out;
  assign gpio_t          = r_tri;

endmodule

// File: tb/tb_axil_gpio_bank.sv
// Directed testbench for axil_gpio_bank (default 4 ports x 8 bits).
module tb_axil_gpio_bank;

  localparam int unsigned NP = 4;
  localparam int unsigned PW = 8;

  logic clk = 1'b0;
  logic reset;
  logic [7:0]  control_awaddr, control_araddr;
  logic        control_awvalid, control_awready, control_wvalid, control_wready;
  logic [31:0] control_wdata, control_rdata;
  logic [1:0]  control_bresp, control_rresp;
  logic        control_bvalid, control_bready;
  logic        control_arvalid, control_arready, control_rvalid, control_rready;
  logic [NP*PW-1:0] gpio_i, gpio_o, gpio_t;
  logic irq;

  int n_pass  = 0;
  int n_total = 0;

  axil_gpio_bank #(.NUM_PORTS(NP), .PORT_W(PW)) dut (
    .clk(clk), .reset(reset),
    .control_awaddr(control_awaddr), .control_awvalid(control_awvalid),
    .control_awready(control_awready), .control_wdata(control_wdata),
    .control_wvalid(control_wvalid), .control_wready(control_wready),
    .control_bresp(control_bresp), .control_bvalid(control_bvalid),
    .control_bready(control_bready), .control_araddr(control_araddr),
    .control_arvalid(control_arvalid), .control_arready(control_arready),
    .control_rdata(control_rdata), .control_rresp(control_rresp),
    .control_rvalid(control_rvalid), .control_rready(control_rready),
    .gpio_i(gpio_i), .gpio_o(gpio_o), .gpio_t(gpio_t), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Bus driver; resp stays 2'b11 if any handshake times out
  task automatic axi_write(input logic [7:0] a, input logic [31:0] d, output logic [1:0] resp);
    int n;
    resp = 2'b11;
    control_awaddr = a; control_wdata = d;
    control_awvalid = 1'b1; control_wvalid = 1'b1;
    n = 0;
    do begin step(); n++; end while (!control_awready && n < 20);
    if (control_awready) begin
      step();
      control_awvalid = 1'b0; control_wvalid = 1'b0;
      n = 0;
      while (!control_bvalid && n < 20) begin step(); n++; end
      if (control_bvalid) begin
        resp = control_bresp;
        control_bready = 1'b1; step(); control_bready = 1'b0;
      end
    end else begin
      control_awvalid = 1'b0; control_wvalid = 1'b0;
    end
  endtask

  task automatic axi_read(input logic [7:0] a, output logic [31:0] d, output logic [1:0] resp);
    int n;
    resp = 2'b11; d = 'x;
    control_araddr = a; control_arvalid = 1'b1;
    n = 0;
    do begin step(); n++; end while (!control_arready && n < 20);
    if (control_arready) begin
      step();
      control_arvalid = 1'b0;
      n = 0;
      while (!control_rvalid && n < 20) begin step(); n++; end
      if (control_rvalid) begin
        d = control_rdata; resp = control_rresp;
        control_rready = 1'b1; step(); control_rready = 1'b0;
      end
    end else begin
      control_arvalid = 1'b0;
    end
  endtask

  task automatic test_reset();
    logic [31:0] d; logic [1:0] r;
    reset = 1'b1;
    control_awaddr = '0; control_awvalid = 0; control_wdata = '0; control_wvalid = 0;
    control_bready = 0; control_araddr = '0; control_arvalid = 0; control_rready = 0;
    gpio_i = '0;
    repeat (3) step();
    n_total++;
    if ({control_awready, control_wready, control_bvalid, control_arready, control_rvalid, irq} !== 6'b0)
      $display("FAIL reset_hs: got %b want 000000",
               {control_awready, control_wready, control_bvalid, control_arready, control_rvalid, irq});
    else n_pass++;
    n_total++;
    if ({control_bresp, control_rresp, control_rdata} !== 36'h0)
      $display("FAIL reset_resp: got %h want 0", {control_bresp, control_rresp, control_rdata});
    else n_pass++;
    n_total++;
    if (gpio_t !== 32'hFFFF_FFFF || gpio_o !== 32'h0)
      $display("FAIL reset_pins: got t=%h o=%h want t=ffffffff o=0", gpio_t, gpio_o);
    else n_pass++;
    reset = 1'b0;
    step();
    axi_read(8'hF0, d, r);
    n_total++;
    if (d !== 32'h0000_0804 || r !== 2'b00) $display("FAIL info: got %h/%b want 00000804/00", d, r);
    else n_pass++;
    axi_read(8'h04, d, r);
    n_total++;
    if (d !== 32'hFF || r !== 2'b00) $display("FAIL tri_reset: got %h/%b want ff/00", d, r);
    else n_pass++;
  endtask

  task automatic test_write();
    logic [31:0] d; logic [1:0] r;
    axi_write(8'h00, 32'hA5, r);
    n_total++;
    if (r !== 2'b00) $display("FAIL wr_out_resp: got %b want 00", r); else n_pass++;
    axi_write(8'h04, 32'h0F, r);
    n_total++;
    if (r !== 2'b00) $display("FAIL wr_tri_resp: got %b want 00", r); else n_pass++;
    n_total++;
    if (gpio_o !== 32'h0000_00A5 || gpio_t !== 32'hFFFF_FF0F)
      $display("FAIL wr_pins: got o=%h t=%h want o=000000a5 t=ffffff0f", gpio_o, gpio_t);
    else n_pass++;
    axi_read(8'h00, d, r);
    n_total++;
    if (d !== 32'hA5 || r !== 2'b00) $display("FAIL rd_out: got %h/%b want a5/00", d, r); else n_pass++;
    axi_write(8'h30, 32'h1FF, r);
    axi_read(8'h30, d, r);
    n_total++;
    if (d !== 32'hFF || r !== 2'b00) $display("FAIL wide_wr: got %h/%b want ff/00", d, r); else n_pass++;
    n_total++;
    if (gpio_o !== 32'hFF00_00A5) $display("FAIL wide_pins: got %h want ff0000a5", gpio_o); else n_pass++;
  endtask

  task automatic test_input();
    logic [31:0] d; logic [1:0] r;
    gpio_i = 32'h0000_3C00;
    axi_read(8'h18, d, r);
    n_total++;
    if (d !== 32'h0) $display("FAIL in_early: got %h want 0", d); else n_pass++;
    axi_read(8'h18, d, r);
    n_total++;
    if (d !== 32'h3C || r !== 2'b00) $display("FAIL in_p1: got %h/%b want 3c/00", d, r); else n_pass++;
    gpio_i = 32'h0000_3C81;
    repeat (3) step();
    axi_read(8'h08, d, r);
    n_total++;
    if (d !== 32'h81) $display("FAIL in_p0_tri: got %h want 81", d); else n_pass++;
    axi_write(8'h18, 32'hFF, r);
    n_total++;
    if (r !== 2'b00) $display("FAIL wr_ro_resp: got %b want 00", r); else n_pass++;
    axi_read(8'h18, d, r);
    n_total++;
    if (d !== 32'h3C) $display("FAIL ro_kept: got %h want 3c", d); else n_pass++;
  endtask

  task automatic test_unmapped();
    logic [31:0] d; logic [1:0] r;
    axi_read(8'h50, d, r);
    n_total++;
    if (d !== 32'h0 || r !== 2'b10) $display("FAIL rd_0x50: got %h/%b want 0/10", d, r); else n_pass++;
    axi_write(8'h48, 32'h12, r);
    n_total++;
    if (r !== 2'b10) $display("FAIL wr_0x48: got %b want 10", r); else n_pass++;
    n_total++;
    if (gpio_o !== 32'hFF00_00A5 || gpio_t !== 32'hFFFF_FF0F)
      $display("FAIL unmapped_state: got o=%h t=%h want ff0000a5/ffffff0f", gpio_o, gpio_t);
    else n_pass++;
    axi_read(8'h02, d, r);
    n_total++;
    if (d !== 32'h0 || r !== 2'b10) $display("FAIL rd_unaligned: got %h/%b want 0/10", d, r); else n_pass++;
    axi_read(8'hF8, d, r);
    n_total++;
    if (r !== 2'b10) $display("FAIL rd_0xf8: got %b want 10", r); else n_pass++;
  endtask

  task automatic test_irq();
    logic [31:0] d; logic [1:0] r;
`ifdef GPIO_IRQ_EN
    int n;
    gpio_i = '0;
    repeat (4) step();
    axi_write(8'h0C, 32'hFF, r);
    axi_write(8'h1C, 32'hFF, r);
    axi_write(8'hF4, 32'h2, r);
    axi_read(8'hF4, d, r);
    n_total++;
    if (d !== 32'h2 || r !== 2'b00) $display("FAIL mask_rd: got %h/%b want 2/00", d, r); else n_pass++;
    gpio_i = 32'h0000_0100;
    repeat (3) step();
    n_total++;
    if (irq !== 1'b0) $display("FAIL irq_early: got %b want 0", irq); else n_pass++;
    step();
    n_total++;
    if (irq !== 1'b1) $display("FAIL irq_rise: got %b want 1", irq); else n_pass++;
    axi_read(8'h1C, d, r);
    n_total++;
    if (d !== 32'h01 || r !== 2'b00) $display("FAIL edge_rd: got %h/%b want 01/00", d, r); else n_pass++;
    axi_write(8'h1C, 32'h01, r);
    n_total++;
    if (irq !== 1'b0) $display("FAIL irq_clear: got %b want 0", irq); else n_pass++;
    gpio_i = 32'h0000_0101;
    repeat (5) step();
    n_total++;
    if (irq !== 1'b0) $display("FAIL irq_masked: got %b want 0", irq); else n_pass++;
    axi_read(8'h0C, d, r);
    n_total++;
    if (d !== 32'h01) $display("FAIL edge_p0: got %h want 01", d); else n_pass++;
    // Rising edge on bit 9 lands on the same edge as a clear of bit 9
    gpio_i = 32'h0000_0301;
    step();
    control_awaddr = 8'h1C; control_wdata = 32'h02;
    control_awvalid = 1'b1; control_wvalid = 1'b1;
    step();
    n_total++;
    if (control_awready !== 1'b1) $display("FAIL race_aw: got %b want 1", control_awready); else n_pass++;
    step();
    control_awvalid = 1'b0; control_wvalid = 1'b0;
    n = 0;
    while (!control_bvalid && n < 20) begin step(); n++; end
    control_bready = 1'b1; step(); control_bready = 1'b0;
    axi_read(8'h1C, d, r);
    n_total++;
    if (d !== 32'h02) $display("FAIL set_wins: got %h want 02", d); else n_pass++;
    axi_write(8'h1C, 32'h02, r);
    axi_read(8'h1C, d, r);
    n_total++;
    if (d !== 32'h00) $display("FAIL edge_cleared: got %h want 00", d); else n_pass++;
`else
    gpio_i = 32'h0000_0000;
    repeat (3) step();
    axi_write(8'hF4, 32'hF, r);
    n_total++;
    if (r !== 2'b00) $display("FAIL mask_wr_resp: got %b want 00", r); else n_pass++;
    gpio_i = 32'h0000_0100;
    repeat (6) step();
    n_total++;
    if (irq !== 1'b0) $display("FAIL irq_off: got %b want 0", irq); else n_pass++;
    axi_read(8'h1C, d, r);
    n_total++;
    if (d !== 32'h0 || r !== 2'b00) $display("FAIL edge_off: got %h/%b want 0/00", d, r); else n_pass++;
    axi_read(8'hF4, d, r);
    n_total++;
    if (d !== 32'h0 || r !== 2'b00) $display("FAIL mask_off: got %h/%b want 0/00", d, r); else n_pass++;
`endif
  endtask

  task automatic test_concurrent();
    logic [31:0] d; logic [1:0] r;
    int n;
    axi_write(8'h20, 32'h11, r);
    control_awaddr = 8'h20; control_wdata = 32'h22;
    control_awvalid = 1'b1; control_wvalid = 1'b1;
    control_araddr = 8'h20; control_arvalid = 1'b1;
    n = 0;
    do begin step(); n++; end while (!control_awready && n < 20);
    n_total++;
    if (control_arready !== 1'b1) $display("FAIL conc_ar: got %b want 1", control_arready); else n_pass++;
    step();
    control_awvalid = 1'b0; control_wvalid = 1'b0; control_arvalid = 1'b0;
    n = 0;
    while (!(control_bvalid && control_rvalid) && n < 20) begin step(); n++; end
    n_total++;
    if (control_rdata !== 32'h11 || control_rvalid !== 1'b1)
      $display("FAIL conc_old: got %h v=%b want 11 v=1", control_rdata, control_rvalid);
    else n_pass++;
    control_bready = 1'b1; control_rready = 1'b1; step();
    control_bready = 1'b0; control_rready = 1'b0;
    axi_read(8'h20, d, r);
    n_total++;
    if (d !== 32'h22) $display("FAIL conc_new: got %h want 22", d); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int n;
    control_awaddr = 8'h14; control_wdata = 32'h00;
    control_awvalid = 1'b1; control_wvalid = 1'b1;
    n = 0;
    do begin step(); n++; end while (!control_awready && n < 20);
    step();
    control_awaddr = 8'h24; control_wdata = 32'hF0;
    n = 0;
    while (!control_bvalid && n < 20) begin step(); n++; end
    control_bready = 1'b1; step(); control_bready = 1'b0;
    n_total++;
    if (control_awready !== 1'b0) $display("FAIL b2b_gap: got %b want 0", control_awready); else n_pass++;
    n = 0;
    while (!control_awready && n < 20) begin step(); n++; end
    step();
    control_awvalid = 1'b0; control_wvalid = 1'b0;
    n = 0;
    while (!control_bvalid && n < 20) begin step(); n++; end
    control_bready = 1'b1; step(); control_bready = 1'b0;
    n_total++;
    if (gpio_t !== 32'hFFF0_000F) $display("FAIL b2b_tri: got %h want fff0000f", gpio_t); else n_pass++;
  endtask

  task automatic test_hold_reset();
    logic [31:0] d; logic [1:0] r;
    int n, bad;
    control_awaddr = 8'h10; control_wdata = 32'h5A;
    control_awvalid = 1'b1; control_wvalid = 1'b1;
    n = 0;
    do begin step(); n++; end while (!control_awready && n < 20);
    step();
    control_awvalid = 1'b0; control_wvalid = 1'b0;
    n_total++;
    if (control_bvalid !== 1'b1 || gpio_o[15:8] !== 8'h5A)
      $display("FAIL wr_latency: got bv=%b o=%h want bv=1 o=5a", control_bvalid, gpio_o[15:8]);
    else n_pass++;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if ({control_bvalid, control_bresp} !== 3'b100) bad++;
    end
    n_total++;
    if (bad !== 0) $display("FAIL b_hold: got %0d unstable cycles want 0", bad); else n_pass++;
    control_bready = 1'b1; step(); control_bready = 1'b0;
    n_total++;
    if (control_bvalid !== 1'b0) $display("FAIL b_drop: got %b want 0", control_bvalid); else n_pass++;
    control_araddr = 8'h10; control_arvalid = 1'b1;
    n = 0;
    do begin step(); n++; end while (!control_arready && n < 20);
    step();
    control_arvalid = 1'b0;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if ({control_rvalid, control_rresp, control_rdata} !== {1'b1, 2'b00, 32'h5A}) bad++;
      step();
    end
    n_total++;
    if (bad !== 0) $display("FAIL r_hold: got %0d unstable cycles want 0", bad); else n_pass++;
    control_awaddr = 8'h00; control_wdata = 32'h33;
    control_awvalid = 1'b1; control_wvalid = 1'b1;
    n = 0;
    do begin step(); n++; end while (!control_awready && n < 20);
    step();
    control_awvalid = 1'b0; control_wvalid = 1'b0;
    reset = 1'b1;
    step();
    n_total++;
    if ({control_bvalid, control_rvalid, control_awready, control_arready} !== 4'b0)
      $display("FAIL rst_mid: got %b want 0000",
               {control_bvalid, control_rvalid, control_awready, control_arready});
    else n_pass++;
    n_total++;
    if (gpio_o !== 32'h0 || gpio_t !== 32'hFFFF_FFFF)
      $display("FAIL rst_pins: got o=%h t=%h want 0/ffffffff", gpio_o, gpio_t);
    else n_pass++;
    reset = 1'b0;
    repeat (3) step();
    n_total++;
    if ({control_bvalid, control_rvalid} !== 2'b00)
      $display("FAIL rst_no_resp: got %b want 00", {control_bvalid, control_rvalid});
    else n_pass++;
    axi_read(8'h00, d, r);
    n_total++;
    if (d !== 32'h0 || r !== 2'b00) $display("FAIL rst_out: got %h/%b want 0/00", d, r); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_write();
    test_input();
    test_unmapped();
    test_irq();
    test_concurrent();
    test_back_to_back();
    test_hold_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
